// File: rtl/pplimit_mc_if.sv
// Bus bundle for the multi-channel shift/round/clip limiter.
// The master side supplies samples and config; the slave side returns limited samples and clip status.
interface pplimit_mc_if #(
  parameter int W_IN    = 16,
  parameter int W_OUT   = 10,
  parameter int NCH     = 4,
  parameter int CW      = 2,
  parameter int SHIFT_W = 4
) ();
  logic signed [W_IN-1:0]  in;
  logic                    strobe_in;
  logic                    frame;
  logic [SHIFT_W-1:0]      shift;
  logic                    lim_we;
  logic [CW-1:0]           lim_addr;
  logic [W_OUT-2:0]        lim_data;
  logic                    clip_clr;
  logic signed [W_OUT-1:0] out;
  logic                    strobe_out;
  logic [CW-1:0]           chan_out;
  logic [NCH-1:0]          clip_flags;
  logic [15:0]             clip_count;

  modport master (
    output in, strobe_in, frame, shift, lim_we, lim_addr, lim_data, clip_clr,
    input  out, strobe_out, chan_out, clip_flags, clip_count
  );

  modport slave (
    input  in, strobe_in, frame, shift, lim_we, lim_addr, lim_data, clip_clr,
    output out, strobe_out, chan_out, clip_flags, clip_count
  );
endinterface

// File: rtl/pplimit_mc.sv
// Time-interleaved multi-channel limiter: rounding right shift, then symmetric clip against a per-channel limit.
// Two-stage pipeline with sticky per-channel clip flags and a saturating clip event counter.
module pplimit_mc #(
  parameter int W_IN    = 16,
  parameter int W_OUT   = 10,
  parameter int NCH     = 4,
  parameter int CW      = 2,
  parameter int SHIFT_W = 4
) (
  input logic         clk,
  input logic         rst_n,
  pplimit_mc_if.slave bus
);
  localparam int KMAX = W_IN - 1;
  localparam logic [W_OUT-2:0] LIM_RST = '1;

  logic [CW-1:0]           cnt_q, cnt_d, ch_in;
  logic                    v1_q, v1_d;
  logic signed [W_IN:0]    s1_q, s1_d;
  logic [CW-1:0]           ch1_q, ch1_d;
  logic signed [W_OUT-1:0] out_q, out_d;
  logic                    strobe_out_q, strobe_out_d;
  logic [CW-1:0]           chan_out_q, chan_out_d;
  logic [NCH-1:0]          flags_q, flags_d;
  logic [15:0]             count_q, count_d;
  logic [W_OUT-2:0]        lim_q [NCH];
  logic [W_OUT-2:0]        lim_d [NCH];

  logic [31:0]             k;
  logic signed [W_IN:0]    rnd, sum, s_in;
  logic [W_OUT-2:0]        lim_rd;
  logic signed [W_IN:0]    lim_s, neg_lim;
  logic                    clip_hi, clip_lo;

  // Stage 1: channel tracking plus rounding shift; one guard bit keeps +full-scale rounding from wrapping.
  always_comb begin
    k = (32'(bus.shift) > KMAX) ? KMAX : 32'(bus.shift);
    rnd = '0;
    if (k != 0) rnd = (W_IN+1)'(1) << (k - 1);
    sum  = {bus.in[W_IN-1], bus.in} + rnd;
    s_in = sum >>> k;
    ch_in = bus.frame ? '0 : cnt_q;

    cnt_d = cnt_q;
    v1_d  = bus.strobe_in;
    s1_d  = s1_q;
    ch1_d = ch1_q;
    if (bus.strobe_in) begin
      s1_d  = s_in;
      ch1_d = ch_in;
      cnt_d = (ch_in == CW'(NCH - 1)) ? '0 : ch_in + CW'(1);
    end
  end

  // Stage 2: clip against the limit as registered before any same-edge write.
  always_comb begin
    lim_rd  = lim_q[ch1_q];
    lim_s   = signed'({{(W_IN+2-W_OUT){1'b0}}, lim_rd});
    neg_lim = -lim_s;
    clip_hi = s1_q > lim_s;
    clip_lo = s1_q < neg_lim;

    out_d        = out_q;
    strobe_out_d = v1_q;
    chan_out_d   = chan_out_q;
    flags_d      = bus.clip_clr ? '0 : flags_q;
    count_d      = bus.clip_clr ? '0 : count_q;
    if (v1_q) begin
      chan_out_d = ch1_q;
      if (clip_hi)      out_d = lim_s[W_OUT-1:0];
      else if (clip_lo) out_d = neg_lim[W_OUT-1:0];
      else              out_d = s1_q[W_OUT-1:0];
      if (clip_hi || clip_lo) begin
        flags_d[ch1_q] = 1'b1;
        if (count_d != 16'hFFFF) count_d = count_d + 16'd1;
      end
    end

    for (int i = 0; i < NCH; i++)
      lim_d[i] = (bus.lim_we && bus.lim_addr == CW'(i)) ? bus.lim_data : lim_q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      v1_q         <= 1'b0;
      s1_q         <= '0;
      ch1_q        <= '0;
      out_q        <= '0;
      strobe_out_q <= 1'b0;
      chan_out_q   <= '0;
      flags_q      <= '0;
      count_q      <= '0;
      for (int i = 0; i < NCH; i++) lim_q[i] <= LIM_RST;
    end else begin
      cnt_q        <= cnt_d;
      v1_q         <= v1_d;
      s1_q         <= s1_d;
      ch1_q        <= ch1_d;
      out_q        <= out_d;
      strobe_out_q <= strobe_out_d;
      chan_out_q   <= chan_out_d;
      flags_q      <= flags_d;
      count_q      <= count_d;
      for (int i = 0; i < NCH; i++) lim_q[i] <= lim_d[i];
    end
  end

  assign bus.out        = out_q;
  assign bus.strobe_out = strobe_out_q;
  assign bus.chan_out   = chan_out_q;
  assign bus.clip_flags = flags_q;
  assign bus.clip_count = count_q;
endmodule

// File: tb/tb_pplimit_mc.sv
// Directed plus randomized bench for pplimit_mc, checked every cycle against an integer-arithmetic model.
// The model tracks limits, channel order and the two-cycle latency using plain ints.
module tb_pplimit_mc;
  localparam int W_IN = 16, W_OUT = 10, NCH = 4, CW = 2, SHIFT_W = 4;

  logic clk, rst_n;
  pplimit_mc_if #(.W_IN(W_IN), .W_OUT(W_OUT), .NCH(NCH), .CW(CW), .SHIFT_W(SHIFT_W)) bus ();

  pplimit_mc #(.W_IN(W_IN), .W_OUT(W_OUT), .NCH(NCH), .CW(CW), .SHIFT_W(SHIFT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passes = 0, total = 0;
  int cur_shift = 0;

  int m_lim [NCH];
  int m_cnt;
  bit p_v;
  int p_s, p_ch;
  bit e_stb;
  int e_out, e_chan, e_count;
  bit [NCH-1:0] e_flags;

  function automatic int shifted(int x, int sh);
    int kk, d, num, q;
    kk = (sh > W_IN - 1) ? W_IN - 1 : sh;
    if (kk == 0) return x;
    d   = 1 << kk;
    num = x + d / 2;
    q   = num / d;
    if (num < 0 && (num % d) != 0) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) m_lim[i] = (1 << (W_OUT - 1)) - 1;
    m_cnt = 0; p_v = 0; p_s = 0; p_ch = 0;
    e_stb = 0; e_out = 0; e_chan = 0; e_count = 0; e_flags = '0;
  endtask

  // One clock edge of the reference: output stage from the old sample/limits, then capture, then writes.
  task automatic model_edge(int din, bit stb, bit frm, bit we, int addr, int data, bit clr);
    int lim, v, ch;
    bit clip;
    e_stb = p_v;
    if (clr) begin e_flags = '0; e_count = 0; end
    if (p_v) begin
      lim = m_lim[p_ch];
      v = p_s; clip = 0;
      if (v > lim) begin v = lim; clip = 1; end
      else if (v < -lim) begin v = -lim; clip = 1; end
      e_out = v; e_chan = p_ch;
      if (clip) begin
        e_flags[p_ch] = 1'b1;
        if (e_count < 65535) e_count++;
      end
    end
    if (stb) begin
      ch = frm ? 0 : m_cnt;
      p_v = 1; p_s = shifted(din, cur_shift); p_ch = ch;
      m_cnt = (ch + 1) % NCH;
    end else p_v = 0;
    if (we && addr < NCH) m_lim[addr] = data;
  endtask

  task automatic chk(string tag, logic signed [31:0] got, logic signed [31:0] exp);
    total++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
  endtask

  task automatic check_all();
    chk("strobe_out", bus.strobe_out, e_stb);
    chk("out", bus.out, e_out);
    chk("chan_out", bus.chan_out, e_chan);
    chk("clip_flags", bus.clip_flags, e_flags);
    chk("clip_count", bus.clip_count, e_count);
  endtask

  task automatic step(int din, bit stb, bit frm, bit we = 0, int addr = 0, int data = 0, bit clr = 0);
    bus.in = W_IN'(din); bus.strobe_in = stb; bus.frame = frm;
    bus.shift = SHIFT_W'(cur_shift);
    bus.lim_we = we; bus.lim_addr = CW'(addr); bus.lim_data = (W_OUT-1)'(data);
    bus.clip_clr = clr;
    @(posedge clk);
    model_edge(din, stb, frm, we, addr, data, clr);
    #1;
    check_all();
  endtask

  task automatic send(int din, int exp_out);
    step(din, 1, 1);
    step(0, 0, 0);
    chk("const_out", bus.out, exp_out);
    step(0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in = '0; bus.strobe_in = 0; bus.frame = 0; bus.shift = '0;
    bus.lim_we = 0; bus.lim_addr = '0; bus.lim_data = '0; bus.clip_clr = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    #3 rst_n = 1'b1;
    step(0, 0, 0);

    // Clip at default limit and rounding behaviour
    cur_shift = 0;
    send(600, 511);
    chk("flags_first", bus.clip_flags, 1);
    chk("count_first", bus.clip_count, 1);
    send(-600, -511);
    send(-512, -511);
    send(300, 300);
    chk("count_noclip", bus.clip_count, 3);
    cur_shift = 2;
    send(7, 2);
    send(-7, -2);
    send(6, 2);
    cur_shift = 15;
    send(32767, 1);
    cur_shift = 0;

    // Per-channel limits across one frame
    step(0, 0, 0, 1, 0, 100);
    step(0, 0, 0, 1, 1, 200);
    step(0, 0, 0, 1, 2, 300);
    step(0, 0, 0, 1, 3, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(250, 1, 1);
    step(250, 1, 0);
    chk("frame_out0", bus.out, 100);
    step(250, 1, 0);
    chk("frame_out1", bus.out, 200);
    step(250, 1, 0);
    chk("frame_out2", bus.out, 250);
    chk("frame_chan2", bus.chan_out, 2);
    step(0, 0, 0);
    chk("frame_out3", bus.out, 0);
    chk("frame_chan3", bus.chan_out, 3);
    step(0, 0, 0);
    chk("frame_flags", bus.clip_flags, 4'b1011);

    // Clear coinciding with a channel-2 clip
    step(0, 1, 1);
    step(0, 1, 0);
    step(400, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("clr_flags", bus.clip_flags, 4'b0100);
    chk("clr_count", bus.clip_count, 1);

    // Saturation of the event counter
    for (int i = 0; i < 65540; i++) step(1000, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("count_sat", bus.clip_count, 65535);

    // Randomized traffic
    step(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) cur_shift = $urandom_range(0, 15);
      step(int'($signed(16'($urandom))), $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, NCH - 1), $urandom_range(0, 511),
           $urandom_range(0, 30) == 0);
    end
    cur_shift = 0;
    step(0, 0, 0);
    step(0, 0, 0);

    // Reset while a sample is in flight
    step(600, 1, 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #3 rst_n = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);
    chk("rst_no_strobe", bus.strobe_out, 0);
    step(600, 1, 1);
    step(600, 1, 0);
    chk("rst_lim0", bus.out, 511);
    step(0, 0, 0);
    chk("rst_lim1", bus.out, 511);
    chk("rst_chan1", bus.chan_out, 1);
    step(0, 0, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
